gshare_req_scheduler: RTL and testbench

Sequences the gshare predictor (datapath + control path) on behalf of two requesters: fetch (predict) and execute (resolve/update). Buffers resolve requests in a small FIFO and arbitrates the single predictor. Issues one-cycle start_pred/start_resolve pulses and waits for DONE, with a timeout watchdog. Returns predict responses over a valid/ready handshake.

---
 rtl/gshare_sched_pkg.sv | 25 ++
 rtl/gshare_resolve_fifo.sv | 77 +++++++
 rtl/gshare_req_scheduler.sv | 172 +++++++++++++++++
 tb/tb_gshare_req_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_sched_pkg.sv
// Shared types and defaults for the gshare request scheduler.
// Holds the FSM state encoding and the queued resolve entry layout.
package gshare_sched_pkg;

    localparam int W_DEF          = 32;
    localparam int RQ_DEPTH_DEF   = 4;
    localparam int STARVE_MAX_DEF = 3;
    localparam int TIMEOUT_DEF    = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_P = 3'd1,
        S_WAIT_P  = 3'd2,
        S_ISSUE_R = 3'd3,
        S_WAIT_R  = 3'd4,
        S_RESP    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [W_DEF-1:0] pc;
        logic [W_DEF-1:0] target;
        logic             hit;
    } res_entry_t;

endpackage

// File: rtl/gshare_resolve_fifo.sv
// Resolve request FIFO with a registered head entry.
// Head reflects the oldest entry one cycle after any push/pop.
module gshare_resolve_fifo
    import gshare_sched_pkg::*;
#(
    parameter int DEPTH = RQ_DEPTH_DEF,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  res_entry_t    push_data,
    input  logic          pop,
    output res_entry_t    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    res_entry_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_nxt;
    logic [CW-1:0]     count_nxt;
    logic              do_push;
    logic              do_pop;
    res_entry_t        head_nxt;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_nxt  = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_nxt = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Bypass the write port when the pushed entry becomes the new head.
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            if (do_push && (wr_ptr == rd_nxt))
                head_nxt = push_data;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/gshare_req_scheduler.sv
// Arbitrates fetch predicts and queued execute resolves onto one
// gshare predictor, with start pulses, done wait and a watchdog.
module gshare_req_scheduler
    import gshare_sched_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int RQ_DEPTH   = RQ_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    localparam int CW        = $clog2(RQ_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_valid,
    output logic          pred_ready,
    input  logic [W-1:0]  pred_pc,
    output logic          pred_rsp_valid,
    input  logic          pred_rsp_ready,
    output logic          pred_rsp_taken,
    output logic [W-1:0]  pred_rsp_target,
    output logic          pred_rsp_timeout,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [W-1:0]  res_pc,
    input  logic [W-1:0]  res_target,
    input  logic          res_hit,
    output logic          bp_start_pred,
    output logic          bp_start_resolve,
    output logic [W-1:0]  bp_pc,
    output logic [W-1:0]  bp_actual_target,
    output logic          bp_pr_hit,
    input  logic          bp_br_pred,
    input  logic [W-1:0]  bp_target,
    input  logic          bp_done,
    output logic [CW-1:0] res_count,
    output logic          err_sticky
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_t  state;
    res_entry_t    push_ent;
    res_entry_t    head_ent;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          res_win;
    logic          pred_win;
    logic          wd_expired;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_nxt;
    logic [TW-1:0] wd;

    assign push_ent.pc     = W_DEF'(res_pc);
    assign push_ent.target = W_DEF'(res_target);
    assign push_ent.hit    = res_hit;

    assign res_ready = !fifo_full;
    assign push      = res_valid && res_ready;

    gshare_resolve_fifo #(
        .DEPTH (RQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (res_count)
    );

    assign res_win = !fifo_empty &&
                     (fifo_full || !pred_valid ||
                      starve == SW'(STARVE_MAX));
    assign pred_win   = pred_valid && !res_win;
    assign pred_ready = (state == S_IDLE) && pred_win;

    assign wd_expired = (wd == TW'(TIMEOUT - 1));
    assign pop = (state == S_WAIT_R) && (bp_done || wd_expired);

    always_comb begin
        starve_nxt = starve;
        if (state == S_IDLE && res_win)
            starve_nxt = '0;
        else if (state == S_IDLE && pred_win && !fifo_empty)
            starve_nxt = starve + 1'b1;
        else if (fifo_empty)
            starve_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            starve           <= '0;
            wd               <= '0;
            bp_start_pred    <= 1'b0;
            bp_start_resolve <= 1'b0;
            bp_pc            <= '0;
            bp_actual_target <= '0;
            bp_pr_hit        <= 1'b0;
            pred_rsp_valid   <= 1'b0;
            pred_rsp_taken   <= 1'b0;
            pred_rsp_target  <= '0;
            pred_rsp_timeout <= 1'b0;
            err_sticky       <= 1'b0;
        end else begin
            starve           <= starve_nxt;
            bp_start_pred    <= 1'b0;
            bp_start_resolve <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (res_win) begin
                        state            <= S_ISSUE_R;
                        bp_start_resolve <= 1'b1;
                        bp_pc            <= head_ent.pc[W-1:0];
                        bp_actual_target <= head_ent.target[W-1:0];
                        bp_pr_hit        <= head_ent.hit;
                    end else if (pred_win) begin
                        state         <= S_ISSUE_P;
                        bp_start_pred <= 1'b1;
                        bp_pc         <= pred_pc;
                    end
                end
                S_ISSUE_P: state <= S_WAIT_P;
                S_ISSUE_R: state <= S_WAIT_R;
                S_WAIT_P: begin
                    // A done arriving on the expiry cycle still wins.
                    if (bp_done || wd_expired) begin
                        state            <= S_RESP;
                        wd               <= '0;
                        bp_pc            <= '0;
                        pred_rsp_valid   <= 1'b1;
                        pred_rsp_taken   <= bp_done && bp_br_pred;
                        pred_rsp_target  <= bp_done ? bp_target : '0;
                        pred_rsp_timeout <= !bp_done;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (bp_done || wd_expired) begin
                        state            <= S_IDLE;
                        wd               <= '0;
                        bp_pc            <= '0;
                        bp_actual_target <= '0;
                        bp_pr_hit        <= 1'b0;
                        if (!bp_done)
                            err_sticky <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_RESP: begin
                    if (pred_rsp_ready) begin
                        state            <= S_IDLE;
                        pred_rsp_valid   <= 1'b0;
                        pred_rsp_taken   <= 1'b0;
                        pred_rsp_target  <= '0;
                        pred_rsp_timeout <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_req_scheduler.sv
// Directed bench for gshare_req_scheduler; the bench plays the predictor.
// Each task drives one scenario and compares against hand-derived values.
module tb_gshare_req_scheduler;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_rsp_valid;
    logic        pred_rsp_ready;
    logic        pred_rsp_taken;
    logic [31:0] pred_rsp_target;
    logic        pred_rsp_timeout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_hit;
    logic        bp_start_pred;
    logic        bp_start_resolve;
    logic [31:0] bp_pc;
    logic [31:0] bp_actual_target;
    logic        bp_pr_hit;
    logic        bp_br_pred;
    logic [31:0] bp_target;
    logic        bp_done;
    logic [2:0]  res_count;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    gshare_req_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_ready       (pred_ready),
        .pred_pc          (pred_pc),
        .pred_rsp_valid   (pred_rsp_valid),
        .pred_rsp_ready   (pred_rsp_ready),
        .pred_rsp_taken   (pred_rsp_taken),
        .pred_rsp_target  (pred_rsp_target),
        .pred_rsp_timeout (pred_rsp_timeout),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_pc           (res_pc),
        .res_target       (res_target),
        .res_hit          (res_hit),
        .bp_start_pred    (bp_start_pred),
        .bp_start_resolve (bp_start_resolve),
        .bp_pc            (bp_pc),
        .bp_actual_target (bp_actual_target),
        .bp_pr_hit        (bp_pr_hit),
        .bp_br_pred       (bp_br_pred),
        .bp_target        (bp_target),
        .bp_done          (bp_done),
        .res_count        (res_count),
        .err_sticky       (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL sim_watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic [31:0] pc,
                            input logic [31:0] tgt,
                            input logic hit);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_target = tgt;
        res_hit    = hit;
        tick();
        res_valid = 1'b0;
    endtask

    // Runs a predict (FIFO empty, IDLE) and leaves it parked in RESP.
    task automatic park_pred(input logic [31:0] pc);
        pred_rsp_ready = 1'b0;
        pred_valid     = 1'b1;
        pred_pc        = pc;
        tick();
        pred_valid = 1'b0;
        tick();
        bp_done    = 1'b1;
        bp_br_pred = 1'b0;
        bp_target  = '0;
        tick();
        bp_done = 1'b0;
    endtask

    task automatic wait_start(output bit gp, output bit gr);
        gp = 1'b0;
        gr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bp_start_pred || bp_start_resolve) begin
                gp = bp_start_pred;
                gr = bp_start_resolve;
                break;
            end
            tick();
        end
    endtask

    task automatic serve_done;
        tick();
        bp_done = 1'b1;
        tick();
        bp_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_res_ready got %b want 1", res_ready); end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL rst_pred_ready got %b want 0", pred_ready); end
        checks++; if (res_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", res_count); end
        checks++; if ({pred_rsp_valid, bp_start_pred, bp_start_resolve, err_sticky} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {pred_rsp_valid, bp_start_pred, bp_start_resolve, err_sticky}); end
        checks++; if ({bp_pc, bp_actual_target, pred_rsp_target} !== 96'd0) begin errors++; $display("FAIL rst_data got %h want 0", {bp_pc, bp_actual_target, pred_rsp_target}); end
    endtask

    task automatic test_predict;
        pred_rsp_ready = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_1000;
        #1;
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL pred_ready got %b want 1", pred_ready); end
        tick();
        pred_valid = 1'b0;
        checks++; if ({bp_start_pred, bp_pc} !== {1'b1, 32'h1000}) begin errors++; $display("FAIL pred_issue got %b/%h want 1/00001000", bp_start_pred, bp_pc); end
        tick();
        checks++; if ({bp_start_pred, bp_pc} !== {1'b0, 32'h1000}) begin errors++; $display("FAIL pred_wait got %b/%h want 0/00001000", bp_start_pred, bp_pc); end
        tick();
        bp_done    = 1'b1;
        bp_br_pred = 1'b1;
        bp_target  = 32'h0000_2000;
        tick();
        bp_done = 1'b0;
        checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target} !== {3'b110, 32'h2000}) begin errors++; $display("FAIL pred_rsp got %b%b%b/%h want 110/00002000", pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target); end
        checks++; if (bp_pc !== 32'd0) begin errors++; $display("FAIL pred_bp_pc_clr got %h want 0", bp_pc); end
        tick();
        checks++; if ({pred_rsp_valid, pred_rsp_target} !== 33'd0) begin errors++; $display("FAIL pred_rsp_clr got %b/%h want 0/0", pred_rsp_valid, pred_rsp_target); end
    endtask

    task automatic test_back_to_back;
        pred_rsp_ready = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_1111;
        tick();
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n1 got %b want 0", pred_ready); end
        tick();
        bp_done    = 1'b1;
        bp_br_pred = 1'b0;
        bp_target  = 32'h0000_1234;
        #1;
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n2 got %b want 0", pred_ready); end
        tick();
        bp_done = 1'b0;
        pred_pc = 32'h0000_2222;
        #1;
        checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_target} !== {2'b10, 32'h1234}) begin errors++; $display("FAIL b2b_rsp_n3 got %b%b/%h want 10/00001234", pred_rsp_valid, pred_rsp_taken, pred_rsp_target); end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n3 got %b want 0", pred_ready); end
        tick();
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n4 got %b want 1", pred_ready); end
        tick();
        pred_valid = 1'b0;
        checks++; if ({bp_start_pred, bp_pc} !== {1'b1, 32'h2222}) begin errors++; $display("FAIL b2b_issue2 got %b/%h want 1/00002222", bp_start_pred, bp_pc); end
        serve_done();
        tick();
    endtask

    task automatic test_drain;
        bit gp, gr;
        logic [31:0] epc;
        logic [31:0] etg;
        logic        ehit;
        park_pred(32'h0000_0010);
        for (int i = 0; i < 3; i++)
            push_res(32'h100 + 32'(i) * 32'h10, 32'hA00 + 32'(i) * 32'h4, ~i[0]);
        checks++; if (res_count !== 3'd3) begin errors++; $display("FAIL drain_count3 got %0d want 3", res_count); end
        pred_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            epc  = 32'h100 + 32'(i) * 32'h10;
            etg  = 32'hA00 + 32'(i) * 32'h4;
            ehit = ~i[0];
            wait_start(gp, gr);
            checks++; if ({gp, gr} !== 2'b01) begin errors++; $display("FAIL drain_grant%0d got %b%b want 01", i, gp, gr); end
            checks++; if ({bp_pc, bp_actual_target, bp_pr_hit} !== {epc, etg, ehit}) begin errors++; $display("FAIL drain_entry%0d got %h/%h/%b want %h/%h/%b", i, bp_pc, bp_actual_target, bp_pr_hit, epc, etg, ehit); end
            serve_done();
            checks++; if (res_count !== 3'(2 - i)) begin errors++; $display("FAIL drain_count%0d got %0d want %0d", i, res_count, 2 - i); end
        end
    endtask

    task automatic test_starve;
        bit gp, gr;
        bit exp_r [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        park_pred(32'h0000_0020);
        push_res(32'h300, 32'hD00, 1'b0);
        push_res(32'h310, 32'hD10, 1'b1);
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_0040;
        pred_rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_start(gp, gr);
            if (k == 7)
                pred_valid = 1'b0;
            checks++; if ({gp, gr} !== {~exp_r[k], exp_r[k]}) begin errors++; $display("FAIL starve_grant%0d got %b%b want %b%b", k, gp, gr, ~exp_r[k], exp_r[k]); end
            serve_done();
        end
        tick();
        checks++; if (res_count !== 3'd0) begin errors++; $display("FAIL starve_count got %0d want 0", res_count); end
    endtask

    task automatic test_full;
        bit gp, gr;
        park_pred(32'h0000_0050);
        for (int i = 0; i < 4; i++)
            push_res(32'h600 + 32'(i) * 32'h10, 32'hB00 + 32'(i), 1'b0);
        checks++; if ({res_ready, res_count} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_state got %b/%0d want 0/4", res_ready, res_count); end
        push_res(32'h999, 32'h999, 1'b1);
        checks++; if (res_count !== 3'd4) begin errors++; $display("FAIL full_overflow got %0d want 4", res_count); end
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_0060;
        pred_rsp_ready = 1'b1;
        wait_start(gp, gr);
        pred_valid = 1'b0;
        checks++; if ({gp, gr, bp_pc} !== {2'b01, 32'h600}) begin errors++; $display("FAIL full_first got %b%b/%h want 01/00000600", gp, gr, bp_pc); end
        serve_done();
        checks++; if ({res_ready, res_count} !== {1'b1, 3'd3}) begin errors++; $display("FAIL full_after_pop got %b/%0d want 1/3", res_ready, res_count); end
        for (int i = 1; i < 4; i++) begin
            wait_start(gp, gr);
            checks++; if ({gr, bp_pc} !== {1'b1, 32'h600 + 32'(i) * 32'h10}) begin errors++; $display("FAIL full_drain%0d got %b/%h want 1/%h", i, gr, bp_pc, 32'h600 + 32'(i) * 32'h10); end
            serve_done();
        end
        checks++; if (res_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", res_count); end
    endtask

    task automatic test_timeout_pred(input bit late_done);
        pred_rsp_ready = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_3000;
        tick();
        pred_valid = 1'b0;
        bp_br_pred = 1'b1;
        bp_target  = late_done ? 32'h0000_4444 : 32'h0000_DEAD;
        tick();
        for (int i = 1; i < 16; i++)
            tick();
        checks++; if (pred_rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early%0d got %b want 0", late_done, pred_rsp_valid); end
        bp_done = late_done;
        tick();
        bp_done = 1'b0;
        if (late_done) begin
            checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target} !== {3'b110, 32'h4444}) begin errors++; $display("FAIL to_done_wins got %b%b%b/%h want 110/00004444", pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target); end
        end else begin
            checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target} !== {3'b101, 32'h0}) begin errors++; $display("FAIL to_pred_rsp got %b%b%b/%h want 101/00000000", pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target); end
        end
        bp_br_pred = 1'b0;
        bp_target  = '0;
        tick();
    endtask

    task automatic test_timeout_res;
        bit gp, gr;
        pred_rsp_ready = 1'b1;
        push_res(32'h700, 32'hC00, 1'b1);
        wait_start(gp, gr);
        checks++; if ({gr, bp_pc, bp_pr_hit} !== {1'b1, 32'h700, 1'b1}) begin errors++; $display("FAIL to_res_issue got %b/%h/%b want 1/00000700/1", gr, bp_pc, bp_pr_hit); end
        tick();
        for (int i = 1; i < 16; i++)
            tick();
        checks++; if ({err_sticky, res_count} !== {1'b0, 3'd1}) begin errors++; $display("FAIL to_res_early got %b/%0d want 0/1", err_sticky, res_count); end
        tick();
        checks++; if ({err_sticky, res_count, bp_pc} !== {1'b1, 3'd0, 32'd0}) begin errors++; $display("FAIL to_res_drop got %b/%0d/%h want 1/0/0", err_sticky, res_count, bp_pc); end
        tick();
        tick();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL to_res_sticky got %b want 1", err_sticky); end
    endtask

    task automatic test_reset_mid;
        pred_rsp_ready = 1'b1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_8000;
        tick();
        pred_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bp_pc, bp_start_pred, pred_rsp_valid, err_sticky, res_count} !== {32'd0, 6'd0}) begin errors++; $display("FAIL rstmid_outs got %h/%b/%b/%b/%0d want 0", bp_pc, bp_start_pred, pred_rsp_valid, err_sticky, res_count); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rstmid_res_ready got %b want 1", res_ready); end
        bp_done    = 1'b1;
        bp_br_pred = 1'b1;
        bp_target  = 32'h77;
        tick();
        bp_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pred_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp%0d got %b want 0", i, pred_rsp_valid); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        pred_rsp_ready = 1'b0;
        pred_valid     = 1'b1;
        pred_pc        = 32'h0000_9000;
        tick();
        pred_valid = 1'b0;
        tick();
        bp_done    = 1'b1;
        bp_br_pred = 1'b1;
        bp_target  = 32'h0000_5555;
        tick();
        bp_done    = 1'b0;
        bp_br_pred = 1'b0;
        bp_target  = 32'h0000_AAAA;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target} !== {3'b110, 32'h5555}) begin errors++; $display("FAIL bp_stall%0d got %b%b%b/%h want 110/00005555", i, pred_rsp_valid, pred_rsp_taken, pred_rsp_timeout, pred_rsp_target); end
            tick();
        end
        pred_rsp_ready = 1'b1;
        tick();
        checks++; if ({pred_rsp_valid, pred_rsp_taken, pred_rsp_target} !== 34'd0) begin errors++; $display("FAIL bp_release got %b%b/%h want 00/0", pred_rsp_valid, pred_rsp_taken, pred_rsp_target); end
    endtask

    initial begin
        rst            = 1'b1;
        pred_valid     = 1'b0;
        pred_pc        = '0;
        pred_rsp_ready = 1'b0;
        res_valid      = 1'b0;
        res_pc         = '0;
        res_target     = '0;
        res_hit        = 1'b0;
        bp_br_pred     = 1'b0;
        bp_target      = '0;
        bp_done        = 1'b0;
        test_reset();
        test_predict();
        test_back_to_back();
        test_drain();
        test_starve();
        test_full();
        test_timeout_pred(1'b0);
        test_timeout_pred(1'b1);
        test_timeout_res();
        test_reset_mid();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
